insn_encoder: RTL and testbench
===============================

INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, the instruction and immediate width.
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have in_valid_i  input  1  request valid; in_ready_o  output  1  request accepted when both are high.
REQ-005 SHALL have opcode_i  input  7  RV32I opcode.
REQ-006 SHALL have rd_i / rs1_i / rs2_i  input  5 each  register indices.
REQ-007 SHALL have funct3_i  input  3 and funct7_i  input  7  function fields.
REQ-008 SHALL have imm_i  input  DWIDTH  full signed or unsigned immediate value, before packing.
REQ-009 SHALL have out_valid_o  output  1 and out_ready_i  input  1  output handshake.
REQ-010 SHALL have insn_o  output  DWIDTH  encoded instruction word.
REQ-011 SHALL have err_o  output  1 and err_code_o  output  2  per-entry error sideband.
REQ-012 SHALL have flush_i  input  1  synchronous buffer clear.
REQ-013 SHALL have enc_count_o / err_count_o  output  16 each  accepted-good and accepted-error counters.

Function
REQ-014 SHALL pack R-type (0110011) as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-015 SHALL pack I-type (JALR, LOAD, OP_IMM, SYSTEM) as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-016 For OP_IMM with funct3 001 or 101, SHALL place funct7_i in [31:25] and imm[4:0] in [24:20].
REQ-017 SHALL pack S-type (STORE) as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-018 SHALL pack B-type (BRANCH) as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-019 SHALL pack U-type (LUI, AUIPC) as {imm[31:12], rd, opcode}.
REQ-020 SHALL pack J-type (JAL) as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-021 Range error (code 01) SHALL be flagged under these conditions:
- I/S: imm[31:11] not all equal.
- Shift form: imm[31:5] nonzero.
- B: imm[31:12] not all equal.
- J: imm[31:20] not all equal.
- U: imm[11:0] nonzero.
REQ-022 Misaligned error (code 10) SHALL be flagged for B or J when imm[0]=1.
REQ-023 Unknown-opcode error (code 11) SHALL be flagged for any other opcode.
REQ-024 Error priority SHALL be 11 > 10 > 01; no error gives code 00.
REQ-025 On any error, the entry SHALL carry insn 32'h00000013 and err=1.
REQ-026 Encoded entries SHALL enter a 2-entry FIFO; in_ready_o = (occupancy < 2), registered state only.
REQ-027 Latency SHALL be 1 cycle: an item accepted at edge N is presented on out_valid_o/insn_o after edge N.
REQ-028 Output SHALL be FIFO-ordered.
REQ-029 insn_o, err_o and err_code_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-030 With occupancy 1, a simultaneous push and pop SHALL leave occupancy 1 with the new item at head next cycle.
REQ-031 With occupancy 2, no push SHALL occur; a pop alone SHALL reduce occupancy to 1.
REQ-032 Read and write pointers SHALL wrap modulo 2.
REQ-033 flush_i=1 SHALL empty the FIFO at the next edge.
REQ-034 An input handshake in a flush cycle SHALL be discarded and not counted.
REQ-035 Counters SHALL be unaffected by flush_i.
REQ-036 enc_count_o SHALL increment on each accepted err=0 item, and err_count_o on each accepted err=1 item.
REQ-037 Both counters SHALL saturate at 16'hFFFF.

Reset
REQ-038 While reset_n=0, without waiting for clk:
- occupancy and pointers = 0
- out_valid_o = 0, in_ready_o = 1
- insn_o = 0, err_o = 0, err_code_o = 00
- both counters = 0
REQ-039 Reset asserted mid-operation SHALL drop all buffered entries with no output handshake.
REQ-040 The first accept SHALL be possible on the first edge after reset_n rises.

Verification
REQ-041 ADDI: opcode 0010011, rd=1, rs1=0, f3=000, imm=5 -> insn 32'h00500093, err 0, enc_count 1.
REQ-042 BEQ: opcode 1100011, rs1=1, rs2=2, f3=000, imm=32'hFFFFFFFC -> insn 32'hFE208EE3.
REQ-043 LUI: rd=5, imm=32'h12345000 -> insn 32'h123452B7.
REQ-044 Error cases:
- JAL imm=3 -> err 1, code 10, insn 32'h00000013, err_count 1.
- Opcode 1111111 -> code 11.
REQ-045 Backpressure: hold out_ready_i=0 and offer 3 items -> in_ready_o=0 after 2 accepts; on release, the 2 items emerge in order, then the third is accepted.
REQ-046 Reset/flush with 2 entries buffered:
- reset_n low -> out_valid_o=0, in_ready_o=1, counters 0 immediately.
- flush_i -> empty next cycle, counters held.

Source files
------------

// File: rtl/insn_encoder.sv
// insn_encoder: packs RV32I instruction fields into a 32-bit word, flags
// range, alignment and unknown-opcode errors, and buffers results in a
// 2-entry FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o request handshake
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i  instruction fields
//   out_valid_o/out_ready_i output handshake
//   insn_o, err_o, err_code_o  head-of-FIFO entry
//   flush_i               synchronous FIFO clear (discards same-cycle input)
//   enc_count_o/err_count_o  saturating counts of accepted good/error items
module insn_encoder #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [DWIDTH-1:0] imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  input  logic              flush_i,
  output logic [15:0]       enc_count_o,
  output logic [15:0]       err_count_o
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned OCC_W   = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_RANGE  = 2'b01;
  localparam logic [1:0] ERR_ALIGN  = 2'b10;
  localparam logic [1:0] ERR_OPC    = 2'b11;

  typedef struct packed {
    logic [DWIDTH-1:0] insn;
    logic              err;
    logic [1:0]        code;
  } entry_t;

  logic [31:0] imm32;
  logic [31:0] raw_insn;
  logic        range_err;
  logic        align_err;
  logic        opc_err;
  entry_t      enc_entry;

  entry_t           mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             push;
  logic             pop;

  assign imm32 = imm_i[31:0];

  // Field packing and error classification for one request.
  always_comb begin
    raw_insn  = '0;
    range_err = 1'b0;
    align_err = 1'b0;
    opc_err   = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        raw_insn = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
        raw_insn  = {imm32[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_err = (imm32[31:11] != {21{imm32[11]}});
      end
      OPC_OP_IMM: begin
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          // Shift-immediate: funct7 supplies the upper bits, shamt is 5 bits.
          raw_insn  = {funct7_i, imm32[4:0], rs1_i, funct3_i, rd_i, opcode_i};
          range_err = |imm32[31:5];
        end else begin
          raw_insn  = {imm32[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          range_err = (imm32[31:11] != {21{imm32[11]}});
        end
      end
      OPC_STORE: begin
        raw_insn  = {imm32[11:5], rs2_i, rs1_i, funct3_i, imm32[4:0], opcode_i};
        range_err = (imm32[31:11] != {21{imm32[11]}});
      end
      OPC_BRANCH: begin
        raw_insn  = {imm32[12], imm32[10:5], rs2_i, rs1_i, funct3_i,
                     imm32[4:1], imm32[11], opcode_i};
        range_err = (imm32[31:12] != {20{imm32[12]}});
        align_err = imm32[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        raw_insn  = {imm32[31:12], rd_i, opcode_i};
        range_err = |imm32[11:0];
      end
      OPC_JAL: begin
        raw_insn  = {imm32[20], imm32[10:1], imm32[11], imm32[19:12],
                     rd_i, opcode_i};
        range_err = (imm32[31:20] != {12{imm32[20]}});
        align_err = imm32[0];
      end
      default: begin
        opc_err = 1'b1;
      end
    endcase
  end

  // Highest-priority error wins; any error replaces the word with a NOP.
  always_comb begin
    enc_entry = '0;
    if (opc_err) begin
      enc_entry.code = ERR_OPC;
    end else if (align_err) begin
      enc_entry.code = ERR_ALIGN;
    end else if (range_err) begin
      enc_entry.code = ERR_RANGE;
    end else begin
      enc_entry.code = ERR_NONE;
    end
    enc_entry.err  = opc_err | align_err | range_err;
    enc_entry.insn = enc_entry.err ? DWIDTH'(NOP_INSN) : DWIDTH'(raw_insn);
  end

  // Handshakes in a flush cycle are ignored on both sides.
  assign push = in_valid_i & in_ready_q & ~flush_i;
  assign pop  = out_valid_q & out_ready_i & ~flush_i;

  always_comb begin
    occ_nxt = occ;
    if (flush_i) begin
      occ_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   occ_nxt = occ + OCC_W'(1);
        2'b01:   occ_nxt = occ - OCC_W'(1);
        default: occ_nxt = occ;
      endcase
    end
  end

  // FIFO state; ready/valid flags are registered from next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ         <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      occ         <= occ_nxt;
      in_ready_q  <= (occ_nxt < OCC_W'(DEPTH));
      out_valid_q <= (occ_nxt != '0);
      if (flush_i) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= enc_entry;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

  // Saturating accept counters; flush only suppresses the push itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (push) begin
      if (!enc_entry.err && enc_cnt != '1) begin
        enc_cnt <= enc_cnt + CNT_W'(1);
      end
      if (enc_entry.err && err_cnt != '1) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign insn_o      = mem[rd_ptr].insn;
  assign err_o       = mem[rd_ptr].err;
  assign err_code_o  = mem[rd_ptr].code;
  assign enc_count_o = enc_cnt;
  assign err_count_o = err_cnt;

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: the driver pushes expected entries as
// requests are accepted; a monitor pops and compares on each output handshake.
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [6:0]  opcode_i = '0;
  logic [4:0]  rd_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] imm_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] insn_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        flush_i = 1'b0;
  logic [15:0] enc_count_o;
  logic [15:0] err_count_o;

  int errors = 0;
  int checks = 0;
  logic [34:0] exp_q [$];

  insn_encoder #(.DWIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .insn_o(insn_o), .err_o(err_o), .err_code_o(err_code_o),
    .flush_i(flush_i),
    .enc_count_o(enc_count_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm;
  endtask

  // Offer one request; expected entry is queued once acceptance is certain.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] e_insn, input logic e_err,
                      input logic [1:0] e_code);
    int waited = 0;
    bit ok = 0;
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    in_valid_i = 1'b1;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (in_ready_o) ok = 1;
      else waited++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: op %b never accepted", op);
    end else begin
      exp_q.push_back({e_insn, e_err, e_code});
    end
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
    end
  endtask

  // Pops on each output handshake and checks holding under backpressure.
  task automatic monitor();
    logic [34:0] prev = '0;
    logic [34:0] cur;
    bit hold = 0;
    forever begin
      @(negedge clk);
      cur = {insn_o, err_o, err_code_o};
      if (hold && reset_n) begin
        chk("hold_valid", 35'(out_valid_o), 35'(1));
        chk("hold_data", cur, prev);
      end
      hold = out_valid_o && !out_ready_i && reset_n && !flush_i;
      prev = cur;
      if (reset_n && !flush_i && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %h with no entry expected", cur);
        end else begin
          chk("output_entry", cur, exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state, observed before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 35'(out_valid_o), 35'(0));
    chk("rst_in_ready", 35'(in_ready_o), 35'(1));
    chk("rst_insn", 35'(insn_o), 35'(0));
    chk("rst_err", 35'(err_o), 35'(0));
    chk("rst_err_code", 35'(err_code_o), 35'(0));
    chk("rst_counts", 35'({enc_count_o, err_count_o}), 35'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;

    // Directed encodings.
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 32'h0050_0093, 1'b0, 2'b00);
    chk("addi_enc_count", 35'(enc_count_o), 35'(1));
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0, 2'b00);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0, 2'b00);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 32'h0020_81B3, 1'b0, 2'b00);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, 32'h4020_81B3, 1'b0, 2'b00);
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'h20, 32'd3, 32'h4031_5093, 1'b0, 2'b00);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8, 32'h0020_A423, 1'b0, 2'b00);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0, 2'b00);
    send(7'b0000011, 5'd5, 5'd1, 5'd0, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_A283, 1'b0, 2'b00);

    // Error cases.
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3, 32'h0000_0013, 1'b1, 2'b10);
    chk("jal_err_count", 35'(err_count_o), 35'(1));
    send(7'b1111111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1, 32'h0000_0013, 1'b1, 2'b11);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048, 32'h0000_0013, 1'b1, 2'b01);
    send(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1, 2'b01);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b001, 7'h00, 32'd32, 32'h0000_0013, 1'b1, 2'b01);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd4096, 32'h0000_0013, 1'b1, 2'b01);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd4097, 32'h0000_0013, 1'b1, 2'b10);
    drain();
    chk("dir_enc_count", 35'(enc_count_o), 35'(9));
    chk("dir_err_count", 35'(err_count_o), 35'(7));

    // Backpressure: two accepted, third waits until the head is popped.
    out_ready_i = 1'b0;
    send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7, 32'h0070_0113, 1'b0, 2'b00);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 32'h0020_81B3, 1'b0, 2'b00);
    chk("bp_full_ready", 35'(in_ready_o), 35'(0));
    chk("bp_full_valid", 35'(out_valid_o), 35'(1));
    fork
      send(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hABCD_E000, 32'hABCD_E0B7, 1'b0, 2'b00);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_full", 35'(in_ready_o), 35'(0));
        out_ready_i = 1'b1;
      end
    join
    drain();
    chk("bp_enc_count", 35'(enc_count_o), 35'(12));

    // Flush with two buffered; the same-cycle request is discarded.
    out_ready_i = 1'b0;
    send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7, 32'h0070_0113, 1'b0, 2'b00);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3, 32'h0000_0013, 1'b1, 2'b10);
    chk("fl_full_ready", 35'(in_ready_o), 35'(0));
    // Let one pop happen so a slot is free and the flush-cycle request is offered against ready=1.
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    set_fields(7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'h00, 32'd9);
    in_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    exp_q.delete();
    chk("fl_out_valid", 35'(out_valid_o), 35'(0));
    chk("fl_in_ready", 35'(in_ready_o), 35'(1));
    chk("fl_enc_count", 35'(enc_count_o), 35'(13));
    chk("fl_err_count", 35'(err_count_o), 35'(8));

    // Reset with two buffered drops everything immediately.
    send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7, 32'h0070_0113, 1'b0, 2'b00);
    send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'h00, 32'd8, 32'h0080_0193, 1'b0, 2'b00);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mr_out_valid", 35'(out_valid_o), 35'(0));
    chk("mr_in_ready", 35'(in_ready_o), 35'(1));
    chk("mr_counts", 35'({enc_count_o, err_count_o}), 35'(0));

    // First accept on the first edge after reset release.
    set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
    in_valid_i = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready_i = 1'b1;
    exp_q.push_back({32'h0050_0093, 1'b0, 2'b00});
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("post_rst_valid", 35'(out_valid_o), 35'(1));
    chk("post_rst_enc_count", 35'(enc_count_o), 35'(1));
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
